instruction_fetch: RTL and testbench

INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

---
 rtl/instruction_fetch.sv | 110 +++++++++++
 tb/tb_instruction_fetch.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch.sv
// Instruction fetch stage: requests the word at pc each CPU cycle, waits for the
// memory ack (or times out at the end of phase 3), then decodes jump/branch control.
module instruction_fetch (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] pc,
  input  logic [2:0]  state,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic        imem_ack,
  input  logic [15:0] imem_rdata,
  output logic [15:0] instr,
  output logic        jump,
  output logic        beq,
  output logic        bne,
  output logic [15:0] address,
  output logic        fetch_fault
);

  typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, HAVE = 2'd2} fsm_t;

  fsm_t        r_fsm, w_fsm_nxt;
  logic        r_req, r_fault, r_jump, r_beq, r_bne;
  logic [15:0] r_addr, r_instr, r_target;
  logic        w_ph_ok, w_ack, w_start, w_timeout, w_dec_en;
  logic [15:0] w_cur, w_imm_sx, w_tgt;
  logic [3:0]  w_op;

  assign w_ph_ok   = (state <= 3'd4);
  assign w_ack     = (r_fsm == WAIT) && r_req && imem_ack && w_ph_ok;
  assign w_start   = (r_fsm == IDLE) && (state == 3'd0);
  assign w_timeout = (r_fsm == WAIT) && (state == 3'd3) && !w_ack;
  // Decode sees the word that will be in instr after this edge.
  assign w_cur     = w_ack ? imem_rdata : (w_timeout ? 16'h0000 : r_instr);
  assign w_op      = w_cur[15:12];
  assign w_imm_sx  = {{4{w_cur[11]}}, w_cur[11:0]};
  assign w_dec_en  = (state == 3'd3) && (r_fsm != IDLE);

  always_comb begin
    w_tgt = 16'h0000;
    case (w_op)
      4'h1:       w_tgt = {pc[15:12], w_cur[11:0]};
      4'h2, 4'h3: w_tgt = pc + 16'd1 + w_imm_sx;
      default:    w_tgt = 16'h0000;
    endcase
  end

  always_comb begin
    w_fsm_nxt = r_fsm;
    case (r_fsm)
      IDLE:    if (w_start) w_fsm_nxt = WAIT;
      WAIT:    if (w_ack || state == 3'd3) w_fsm_nxt = HAVE;
      HAVE:    if (state == 3'd4) w_fsm_nxt = IDLE;
      default: w_fsm_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_fsm <= IDLE;
    else        r_fsm <= w_fsm_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_req    <= 1'b0;
      r_addr   <= 16'h0000;
      r_instr  <= 16'h0000;
      r_fault  <= 1'b0;
      r_jump   <= 1'b0;
      r_beq    <= 1'b0;
      r_bne    <= 1'b0;
      r_target <= 16'h0000;
    end else begin
      if (w_start) begin
        r_req   <= 1'b1;
        r_addr  <= pc;
        r_fault <= 1'b0;
      end
      if (w_ack) begin
        r_instr <= imem_rdata;
        r_req   <= 1'b0;
      end else if (w_timeout) begin
        r_instr <= 16'h0000;
        r_req   <= 1'b0;
        r_fault <= 1'b1;
      end
      if (w_dec_en) begin
        r_jump   <= (w_op == 4'h1);
        r_beq    <= (w_op == 4'h2);
        r_bne    <= (w_op == 4'h3);
        r_target <= w_tgt;
      end else if (state == 3'd4) begin
        r_jump   <= 1'b0;
        r_beq    <= 1'b0;
        r_bne    <= 1'b0;
        r_target <= 16'h0000;
      end
    end
  end

  assign imem_req    = r_req;
  assign imem_addr   = r_addr;
  assign instr       = r_instr;
  assign fetch_fault = r_fault;
  assign jump        = r_jump;
  assign beq         = r_beq;
  assign bne         = r_bne;
  assign address     = r_target;

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: directed scenarios with literal expectations, then
// randomized fetches (stalls, spurious acks, timeouts) against a behavioural model.
module tb_instruction_fetch;
  logic        clk = 0, rst_n = 0;
  logic [15:0] pc = 0, imem_addr, imem_rdata = 0, instr, address;
  logic [2:0]  state = 0;
  logic        imem_req, imem_ack = 0, jump, beq, bne, fetch_fault;
  logic        rst_drv = 0;
  int          checks = 0, failures = 0;

  // behavioural model of the stage outputs
  logic        m_req = 0, m_fault = 0, m_j = 0, m_b = 0, m_n = 0, m_done = 0;
  logic [15:0] m_addr = 0, m_instr = 0, m_tgt = 0;

  instruction_fetch dut (
    .clk(clk), .rst_n(rst_n), .pc(pc), .state(state),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
    .imem_rdata(imem_rdata), .instr(instr), .jump(jump), .beq(beq), .bne(bne),
    .address(address), .fetch_fault(fetch_fault)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    m_req = 0; m_fault = 0; m_j = 0; m_b = 0; m_n = 0; m_done = 0;
    m_addr = 0; m_instr = 0; m_tgt = 0;
  endtask

  always @(negedge rst_n) model_clear();

  // One clock edge of the fetch rules, applied to the inputs present at that edge.
  task automatic model_step(input logic [2:0] ph, input logic ack, input logic [15:0] rd,
                            input logic [15:0] p);
    bit acc;
    int op, imm, t;
    if (!rst_n) begin model_clear(); return; end
    if (ph > 4) return;
    acc = m_req && ack;
    if (ph == 0 && !m_req && !m_done) begin
      m_req = 1; m_addr = p; m_fault = 0;
    end else if (acc) begin
      m_instr = rd; m_req = 0; m_done = 1;
    end else if (m_req && ph == 3) begin
      m_instr = 0; m_req = 0; m_fault = 1; m_done = 1;
    end
    if (ph == 3 && m_done) begin
      op  = int'(m_instr) / 4096;
      imm = int'(m_instr) % 4096;
      if (imm >= 2048) imm -= 4096;
      m_j = (op == 1); m_b = (op == 2); m_n = (op == 3);
      if (op == 1)                t = (int'(p) / 4096) * 4096 + imm % 4096 + (imm < 0 ? 4096 : 0);
      else if (op == 2 || op == 3) t = (int'(p) + 1 + imm + 65536) % 65536;
      else                        t = 0;
      m_tgt = 16'(t);
    end
    if (ph == 4) begin
      m_j = 0; m_b = 0; m_n = 0; m_tgt = 0; m_done = 0;
    end
  endtask

  // Every cycle: DUT outputs against the model.
  always @(posedge clk) begin
    #1;
    chk("req", {15'b0, imem_req}, {15'b0, m_req});
    if (m_req) chk("imem_addr", imem_addr, m_addr);
    chk("instr", instr, m_instr);
    chk("fault", {15'b0, fetch_fault}, {15'b0, m_fault});
    chk("jump", {15'b0, jump}, {15'b0, m_j});
    chk("beq", {15'b0, beq}, {15'b0, m_b});
    chk("bne", {15'b0, bne}, {15'b0, m_n});
    chk("address", address, m_tgt);
  end

  task automatic cyc(input logic [2:0] ph, input logic ack, input logic [15:0] rd);
    bit prev;
    @(negedge clk);
    prev = rst_n;
    state = ph; imem_ack = ack; imem_rdata = rd; rst_n = rst_drv;
    if (prev && !rst_n) begin
      #1;
      chk("rst_async_req", {15'b0, imem_req}, 16'h0000);
      chk("rst_async_instr", instr, 16'h0000);
    end
    @(posedge clk);
    model_step(ph, ack, rd, pc);
  endtask

  function automatic logic [15:0] rnd_word();
    logic [3:0]  op;
    logic [11:0] lo;
    op = 4'($urandom_range(0, 5));
    lo = 12'($urandom);
    return {op, lo};
  endfunction

  // One CPU cycle (phases 0..4). ackph 1..3 = ack in that phase, 0 = never acked.
  task automatic run_fetch(input logic [15:0] p, input int ackph, input logic [15:0] rd,
                           input bit stalls, input bit lit, input logic [15:0] e_instr,
                           input logic [2:0] e_ctl, input logic [15:0] e_addr, input logic e_fault);
    logic ack;
    for (int ph = 0; ph <= 4; ph++) begin
      if (stalls && $urandom_range(0, 7) == 0)
        cyc(3'($urandom_range(5, 7)), 1'($urandom), rnd_word());
      if (ph == 0) pc = p;
      if (ph == ackph) ack = 1;
      else if (ph == 0 || ph == 4 || (ackph != 0 && ph > ackph)) ack = 1'($urandom);
      else ack = 0;
      cyc(3'(ph), ack, (ph == ackph) ? rd : rnd_word());
      if (ph == 0) begin
        #2;
        chk("fault_clear_at_start", {15'b0, fetch_fault}, 16'h0000);
      end
      if (ph == 3 && lit) begin
        #2;
        chk("lit_instr", instr, e_instr);
        chk("lit_ctl", {13'b0, jump, beq, bne}, {13'b0, e_ctl});
        chk("lit_addr", address, e_addr);
        chk("lit_fault", {15'b0, fetch_fault}, {15'b0, e_fault});
        chk("lit_req_low", {15'b0, imem_req}, 16'h0000);
      end
    end
  endtask

  initial begin
    // held in reset across a few phases
    for (int i = 0; i < 3; i++) cyc(3'(i), 1, 16'h1111);
    chk("reset_instr", instr, 16'h0000);
    chk("reset_req", {15'b0, imem_req}, 16'h0000);
    chk("reset_fault", {15'b0, fetch_fault}, 16'h0000);
    cyc(3, 0, 0);
    rst_drv = 1;
    cyc(4, 0, 0);

    run_fetch(16'h0010, 1, 16'h1234, 0, 1, 16'h1234, 3'b100, 16'h0234, 0);
    run_fetch(16'h0020, 2, 16'h2FFE, 0, 1, 16'h2FFE, 3'b010, 16'h001F, 0);
    run_fetch(16'hFFFF, 1, 16'h3001, 0, 1, 16'h3001, 3'b001, 16'h0001, 0);
    run_fetch(16'h0040, 0, 16'h1FFF, 0, 1, 16'h0000, 3'b000, 16'h0000, 1);
    run_fetch(16'h0100, 3, 16'h3005, 0, 1, 16'h3005, 3'b001, 16'h0106, 0);
    run_fetch(16'h5678, 2, 16'h1ABC, 0, 1, 16'h1ABC, 3'b100, 16'h5ABC, 0);

    // reset pulsed in phase 2 while the request is outstanding
    pc = 16'h0200;
    cyc(0, 0, 0);
    cyc(1, 0, 0);
    chk("pre_rst_req", {15'b0, imem_req}, 16'h0001);
    rst_drv = 0;
    cyc(2, 1, 16'h1000);
    cyc(3, 1, 16'h3005);
    rst_drv = 1;
    cyc(4, 0, 0);
    chk("post_rst_instr", instr, 16'h0000);
    pc = 16'h0300;
    cyc(0, 0, 0);
    #2;
    chk("post_rst_refetch_req", {15'b0, imem_req}, 16'h0001);
    chk("post_rst_refetch_addr", imem_addr, 16'h0300);
    cyc(1, 1, 16'h2001);
    cyc(2, 0, 0);
    cyc(3, 0, 0);
    #2;
    chk("post_rst_beq", {15'b0, beq}, 16'h0001);
    chk("post_rst_addr", address, 16'h0302);
    cyc(4, 0, 0);

    // randomized fetches, with occasional mid-reset
    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 49) == 0) begin
        rst_drv = 0;
        cyc(3'($urandom_range(0, 4)), 0, 0);
        rst_drv = 1;
        // finish out the interrupted cycle so phases stay aligned
        cyc(4, 0, 0);
      end
      run_fetch(16'($urandom), $urandom_range(0, 3), rnd_word(), 1, 0, 0, 0, 0, 0);
    end

    repeat (2) @(posedge clk);
    #3;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
